shift_mul_seq: RTL and testbench

Sequential 4x4 unsigned multiplier controller that computes a product by repeatedly driving the existing combinational 8-bit-output left shifter and accumulating its partial products. It owns the shifter's operand inputs for the whole operation, one shift per clock. It sits between the ALU operation decoder (start/operands) and the ALU result mux (product/done).

---
 rtl/shift_mul_seq.sv | 102 ++++++++++
 tb/tb_shift_mul_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/shift_mul_seq.sv
// shift_mul_seq
//   Sequential 4x4 unsigned multiplier. Drives an external combinational
//   left shifter (R = A << B) once per clock and accumulates the gated
//   partial products over exactly four RUN cycles.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   multiply request, sampled only while ready=1
//   op_a    in   [3:0] multiplicand
//   op_b    in   [3:0] multiplier
//   ready   out  high in IDLE
//   busy    out  high in RUN and DONE
//   sh_a    out  [3:0] shifter value input
//   sh_b    out  [3:0] shifter shift-amount input
//   sh_r    in   [7:0] shifter result, combinational from sh_a/sh_b
//   product out  [7:0] registered product, updated only on RUN->DONE
//   done    out  one-cycle pulse with product valid
module shift_mul_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] op_a,
    input  logic [3:0] op_b,
    output logic       ready,
    output logic       busy,
    output logic [3:0] sh_a,
    output logic [3:0] sh_b,
    input  logic [7:0] sh_r,
    output logic [7:0] product,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e     state_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [1:0] idx_q;
    logic [7:0] acc_q;
    logic [7:0] product_q;

    logic [7:0] pp_d;
    logic [7:0] sum_d;

    // Partial product for the current multiplier bit; the shifter has
    // already produced a_q << idx_q this cycle.
    always_comb begin
        pp_d  = b_q[idx_q] ? sh_r : 8'd0;
        sum_d = acc_q + pp_d;   // max 225, never wraps
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= 4'd0;
            b_q       <= 4'd0;
            idx_q     <= 2'd0;
            acc_q     <= 8'd0;
            product_q <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        acc_q   <= 8'd0;
                        idx_q   <= 2'd0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q <= sum_d;
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        product_q <= sum_d;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // All outputs decode registered state only: no path from start.
    assign ready   = (state_q == S_IDLE);
    assign busy    = (state_q == S_RUN) || (state_q == S_DONE);
    assign done    = (state_q == S_DONE);
    assign sh_a    = (state_q == S_RUN) ? a_q : 4'd0;
    assign sh_b    = (state_q == S_RUN) ? {2'b00, idx_q} : 4'd0;
    assign product = product_q;

endmodule

// File: tb/tb_shift_mul_seq.sv
module tb_shift_mul_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] op_a, op_b;
    logic       ready, busy, done;
    logic [3:0] sh_a, sh_b;
    logic [7:0] sh_r;
    logic [7:0] product;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb[$];
    logic       done_prev = 1'b0;

    always #5 clk = ~clk;

    // Behavioural model of the combinational shifter.
    assign sh_r = {4'b0000, sh_a} << sh_b;

    shift_mul_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .ready  (ready),
        .busy   (busy),
        .sh_a   (sh_a),
        .sh_b   (sh_b),
        .sh_r   (sh_r),
        .product(product),
        .done   (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got product %0d expected no pulse (t=%0t)", product, $time);
            end else begin
                chk("product", {24'd0, product}, {24'd0, sb.pop_front()});
            end
            if (done_prev) chk("done_twice", 32'd1, 32'd0);
        end
        done_prev = done;
    end

    // One full operation with cycle-by-cycle checks. With poke set,
    // start is re-asserted with other operands during RUN and DONE.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input bit poke);
        logic [7:0] p;
        logic [3:0] bm;
        p = 8'(a) * 8'(b);
        @(negedge clk);
        chk("ready_pre", {31'd0, ready}, 32'd1);
        op_a = a; op_b = b; start = 1'b1;
        @(posedge clk);
        sb.push_back(p);
        #1;
        start = 1'b0;
        if (poke) begin op_a = 4'd15; op_b = 4'd15; end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bm = 4'((1 << k) - 1);
            chk("sh_a",     {28'd0, sh_a}, {28'd0, a});
            chk("sh_b",     {28'd0, sh_b}, k);
            chk("busy_run", {31'd0, busy}, 32'd1);
            chk("rdy_run",  {31'd0, ready}, 32'd0);
            chk("done_run", {31'd0, done}, 32'd0);
            chk("acc",      {24'd0, dut.acc_q}, 32'(a) * 32'(b & bm));
            if (poke && k == 1) start = 1'b1;
            if (poke && k == 2) start = 1'b0;
        end
        @(negedge clk);
        chk("done_lat",  {31'd0, done}, 32'd1);
        chk("busy_done", {31'd0, busy}, 32'd1);
        chk("sh_a_done", {28'd0, sh_a}, 32'd0);
        if (poke) start = 1'b1;
        @(negedge clk);
        chk("ready_post", {31'd0, ready}, 32'd1);
        chk("done_post",  {31'd0, done}, 32'd0);
        chk("busy_post",  {31'd0, busy}, 32'd0);
        chk("prod_hold",  {24'd0, product}, {24'd0, p});
        if (poke) start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op_a = 4'd0; op_b = 4'd0;
        #12;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_done",  {31'd0, done},  32'd0);
        chk("rst_prod",  {24'd0, product}, 32'd0);
        chk("rst_sh_a",  {28'd0, sh_a}, 32'd0);
        chk("rst_sh_b",  {28'd0, sh_b}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed vectors
        do_op(4'd15, 4'd15, 1'b0);  // 225
        do_op(4'd5,  4'd10, 1'b0);  // acc 0,10,10,50 -> 50
        do_op(4'd0,  4'd9,  1'b0);  // 0
        do_op(4'd9,  4'd0,  1'b0);  // 0
        do_op(4'd3,  4'd7,  1'b1);  // 21, stray starts ignored
        repeat (4) @(negedge clk);
        chk("sb_after_poke", sb.size(), 32'd0);

        // Reset mid-RUN
        do_op(4'd6, 4'd6, 1'b0);    // 36
        @(negedge clk);
        op_a = 4'd2; op_b = 4'd3; start = 1'b1;
        @(posedge clk);
        sb.push_back(8'd6);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_ready", {31'd0, ready}, 32'd1);
        chk("arst_busy",  {31'd0, busy},  32'd0);
        chk("arst_done",  {31'd0, done},  32'd0);
        chk("arst_prod",  {24'd0, product}, 32'd0);
        chk("arst_sh_a",  {28'd0, sh_a}, 32'd0);
        chk("arst_sh_b",  {28'd0, sh_b}, 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("arst_prod_idle", {24'd0, product}, 32'd0);
        do_op(4'd2, 4'd3, 1'b0);    // 6

        // Back-to-back with start held high: one acceptance per 6 edges.
        @(negedge clk);
        op_a = 4'd1; op_b = 4'd11; start = 1'b1;
        for (int a = 1; a <= 15; a++) begin
            @(posedge clk);
            sb.push_back(8'(a * 11));
            #1;
            op_a = 4'((a % 15) + 1);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                chk("b2b_done", {31'd0, done}, (k == 4) ? 32'd1 : 32'd0);
                chk("b2b_busy", {31'd0, busy}, 32'd1);
            end
            @(negedge clk);
            chk("b2b_ready", {31'd0, ready}, 32'd1);
            if (a == 15) start = 1'b0;
        end
        repeat (8) @(negedge clk);
        chk("b2b_sb_empty", sb.size(), 32'd0);

        // Full operand sweep
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                do_op(4'(a), 4'(b), 1'b0);
        repeat (4) @(negedge clk);
        chk("final_sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
